// File: rtl/conv_window_sequencer_pkg.sv
// Shared operand-width defaults and index-width helper for the convolution window sequencer.
package conv_window_sequencer_pkg;

    localparam int BIT_LENGTH_DEF = 8;
    localparam int PORT_COUNT_DEF = 3;

    // Index width that stays at least one bit for single-entry buffers.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_row_buffer.sv
// Kernel row store: registered write, combinational read; out-of-range writes dropped, reads return zero.
// One-cycle write latency, no backpressure.
module conv_row_buffer
    import conv_window_sequencer_pkg::*;
#(
    parameter int DW   = 24,
    parameter int ROWS = 3
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      wr_en,
    input  logic [idx_bits(ROWS)-1:0] wr_row,
    input  logic [DW-1:0]             wr_pixel,
    input  logic [DW-1:0]             wr_weight,
    input  logic [idx_bits(ROWS)-1:0] rd_row,
    output logic [DW-1:0]             rd_pixel,
    output logic [DW-1:0]             rd_weight
);

    logic [DW-1:0] pix_mem [ROWS];
    logic [DW-1:0] wt_mem  [ROWS];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int r = 0; r < ROWS; r++) begin
                pix_mem[r] <= '0;
                wt_mem[r]  <= '0;
            end
        end else if (wr_en && (32'(wr_row) < 32'(ROWS))) begin
            pix_mem[wr_row] <= wr_pixel;
            wt_mem[wr_row]  <= wr_weight;
        end
    end

    always_comb begin
        rd_pixel  = '0;
        rd_weight = '0;
        if (32'(rd_row) < 32'(ROWS)) begin
            rd_pixel  = pix_mem[rd_row];
            rd_weight = wt_mem[rd_row];
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks one kernel window through the multiplier lanes row by row, then requests and captures the final sum.
// Next row issues one cycle after all lanes report done; every wait state is bounded by TIMEOUT.
module conv_window_sequencer
    import conv_window_sequencer_pkg::*;
#(
    parameter int BIT_LENGTH = BIT_LENGTH_DEF,
    parameter int PORT_COUNT = PORT_COUNT_DEF,
    parameter int ROWS       = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             wr_en,
    input  logic [idx_bits(ROWS)-1:0]        wr_row,
    input  logic [PORT_COUNT*BIT_LENGTH-1:0] wr_pixel,
    input  logic [PORT_COUNT*BIT_LENGTH-1:0] wr_weight,
    input  logic                             start,
    output logic [PORT_COUNT*BIT_LENGTH-1:0] multiplier_out,
    output logic [PORT_COUNT*BIT_LENGTH-1:0] multiplicand_out,
    output logic [PORT_COUNT-1:0]            mStart,
    input  logic [PORT_COUNT-1:0]            mReady,
    output logic                             finalAdd,
    input  logic                             cReady,
    input  logic [2*BIT_LENGTH-1:0]          cSum,
    output logic [2*BIT_LENGTH-1:0]          result,
    output logic                             result_valid,
    output logic                             busy,
    output logic                             error
);

    localparam int DW    = PORT_COUNT * BIT_LENGTH;
    localparam int ROW_W = idx_bits(ROWS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_MUL = 3'd2,
        FINAL    = 3'd3,
        WAIT_SUM = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic [CNT_W-1:0]  wait_cnt;
    logic [PORT_COUNT-1:0] sticky;
    logic [ROW_W-1:0]  rd_row;
    logic [DW-1:0]     rd_pixel;
    logic [DW-1:0]     rd_weight;
    logic              buf_wr;
    logic              lanes_done;

    // Only IDLE may touch the buffer; the read port looks at the row about to be issued.
    assign buf_wr     = wr_en && (state == IDLE);
    assign rd_row     = (state == WAIT_MUL) ? row + ROW_W'(1) : '0;
    assign lanes_done = &(sticky | mReady);

    conv_row_buffer #(
        .DW   (DW),
        .ROWS (ROWS)
    ) u_row_buffer (
        .Clk       (Clk),
        .Rst       (Rst),
        .wr_en     (buf_wr),
        .wr_row    (wr_row),
        .wr_pixel  (wr_pixel),
        .wr_weight (wr_weight),
        .rd_row    (rd_row),
        .rd_pixel  (rd_pixel),
        .rd_weight (rd_weight)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state            <= IDLE;
            row              <= '0;
            wait_cnt         <= '0;
            sticky           <= '0;
            multiplier_out   <= '0;
            multiplicand_out <= '0;
            mStart           <= '0;
            finalAdd         <= 1'b0;
            result           <= '0;
            result_valid     <= 1'b0;
            busy             <= 1'b0;
            error            <= 1'b0;
        end else begin
            mStart       <= '0;
            finalAdd     <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en && (32'(wr_row) >= 32'(ROWS))) begin
                        error <= 1'b1;
                    end
                    if (start) begin
                        row              <= '0;
                        state            <= ISSUE;
                        busy             <= 1'b1;
                        mStart           <= '1;
                        multiplier_out   <= rd_pixel;
                        multiplicand_out <= rd_weight;
                    end
                end
                ISSUE: begin
                    sticky   <= '0;
                    wait_cnt <= '0;
                    state    <= WAIT_MUL;
                end
                WAIT_MUL: begin
                    if (lanes_done) begin
                        if (row != LAST_ROW) begin
                            row              <= row + ROW_W'(1);
                            state            <= ISSUE;
                            mStart           <= '1;
                            multiplier_out   <= rd_pixel;
                            multiplicand_out <= rd_weight;
                        end else begin
                            state    <= FINAL;
                            finalAdd <= 1'b1;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        state            <= IDLE;
                        busy             <= 1'b0;
                        error            <= 1'b1;
                        multiplier_out   <= '0;
                        multiplicand_out <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        sticky   <= sticky | mReady;
                    end
                end
                FINAL: begin
                    wait_cnt <= '0;
                    state    <= WAIT_SUM;
                end
                WAIT_SUM: begin
                    if (cReady) begin
                        result       <= cSum;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state            <= IDLE;
                        busy             <= 1'b0;
                        error            <= 1'b1;
                        multiplier_out   <= '0;
                        multiplicand_out <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state            <= IDLE;
                    busy             <= 1'b0;
                    multiplier_out   <= '0;
                    multiplicand_out <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Writes and starts while a window is in flight are rejected, not queued.
            if ((state != IDLE) && (start || wr_en)) begin
                error <= 1'b1;
            end
        end
    end

endmodule
